// File: rtl/stream_out_sched.sv
// Round-robin output scheduler: shares one AXI4-Stream master among N_CH actor ports,
// granting each in bursts of at most BURST beats until its frame length is exhausted.
module stream_out_sched #(
    parameter int unsigned N_CH   = 4,
    parameter int unsigned IDX_W  = 2,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LEN_W  = 16,
    parameter int unsigned BURST  = 4
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic                   cfg_start,
    input  logic [N_CH-1:0]        cfg_en,
    input  logic [N_CH*LEN_W-1:0]  cfg_len,
    output logic                   busy,
    output logic                   done,
    input  logic [N_CH-1:0]        ch_send,
    input  logic [N_CH*DATA_W-1:0] ch_data,
    output logic [N_CH-1:0]        ch_rdy,
    output logic [N_CH-1:0]        ch_ack,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic [DATA_W-1:0]      m_axis_tdata,
    output logic                   m_axis_tlast,
    output logic [IDX_W-1:0]       m_axis_tuser
);

    typedef enum logic [1:0] {StIdle, StArb, StXfer, StDone} state_e;

    localparam logic [LEN_W-1:0] BurstLen = LEN_W'(BURST);
    localparam logic [LEN_W-1:0] OneBeat  = LEN_W'(1);
    localparam logic [IDX_W-1:0] LastCh   = IDX_W'(N_CH - 1);

    state_e            state_q, state_d;
    logic [N_CH-1:0]   pending_q, pending_d;
    logic [LEN_W-1:0]  remain_q [N_CH];
    logic [LEN_W-1:0]  remain_d [N_CH];
    logic [LEN_W-1:0]  bcnt_q, bcnt_d;
    logic [IDX_W-1:0]  gnt_q, gnt_d;
    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;

    logic [IDX_W-1:0]  arb_idx;
    logic [IDX_W-1:0]  cand;
    logic              arb_found;
    logic [LEN_W-1:0]  cur_rem;
    logic              beat;

    // Cyclic first-set search starting at rr_ptr, wrapping at N_CH.
    always_comb begin
        arb_idx   = rr_ptr_q;
        arb_found = 1'b0;
        cand      = '0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            cand = IDX_W'((32'(rr_ptr_q) + k) % N_CH);
            if (!arb_found && pending_q[cand]) begin
                arb_idx   = cand;
                arb_found = 1'b1;
            end
        end
    end

    assign cur_rem = remain_q[gnt_q];
    assign beat    = ch_send[gnt_q] && m_axis_tready;

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        remain_d  = remain_q;
        bcnt_d    = bcnt_q;
        gnt_d     = gnt_q;
        rr_ptr_d  = rr_ptr_q;

        busy          = 1'b0;
        done          = 1'b0;
        ch_rdy        = '0;
        ch_ack        = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = '0;
        m_axis_tlast  = 1'b0;
        m_axis_tuser  = '0;

        unique case (state_q)
            StIdle: begin
                if (cfg_start) begin
                    for (int unsigned i = 0; i < N_CH; i++) begin
                        remain_d[i]  = cfg_len[i*LEN_W +: LEN_W];
                        pending_d[i] = cfg_en[i] && (cfg_len[i*LEN_W +: LEN_W] != '0);
                    end
                    rr_ptr_d = '0;
                    state_d  = (|pending_d) ? StArb : StDone;
                end
            end
            StArb: begin
                busy    = 1'b1;
                gnt_d   = arb_idx;
                bcnt_d  = (remain_q[arb_idx] < BurstLen) ? remain_q[arb_idx] : BurstLen;
                state_d = StXfer;
            end
            StXfer: begin
                busy                 = 1'b1;
                m_axis_tvalid        = ch_send[gnt_q];
                m_axis_tdata         = ch_data[DATA_W*32'(gnt_q) +: DATA_W];
                m_axis_tlast         = (cur_rem == OneBeat);
                m_axis_tuser         = gnt_q;
                ch_rdy[gnt_q]        = m_axis_tready;
                ch_ack[gnt_q]        = beat;
                if (beat) begin
                    remain_d[gnt_q] = cur_rem - OneBeat;
                    bcnt_d          = bcnt_q - OneBeat;
                    if (cur_rem == OneBeat) begin
                        pending_d[gnt_q] = 1'b0;
                    end
                    // Grant ends on burst exhaustion or frame end; hand over the pointer.
                    if (cur_rem == OneBeat || bcnt_q == OneBeat) begin
                        rr_ptr_d = (gnt_q == LastCh) ? '0 : gnt_q + IDX_W'(1);
                        state_d  = (|pending_d) ? StArb : StDone;
                    end
                end
            end
            StDone: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= StIdle;
            pending_q <= '0;
            bcnt_q    <= '0;
            gnt_q     <= '0;
            rr_ptr_q  <= '0;
            for (int unsigned i = 0; i < N_CH; i++) begin
                remain_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            remain_q  <= remain_d;
            bcnt_q    <= bcnt_d;
            gnt_q     <= gnt_d;
            rr_ptr_q  <= rr_ptr_d;
        end
    end

endmodule
